// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory request controller.
// FSM state encodings, word offset and alignment helper.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int WORD_OFS = 2;

  function automatic logic is_aligned(
    input logic [WORD_OFS-1:0] lo
  );
    return lo == '0;
  endfunction

endpackage

// File: rtl/dmem_stat_counter.sv
// Access / hit / miss statistics counters.
// Wrap at 2^CNT_WIDTH; async active-low clear.
module dmem_stat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 hit,
  output logic [CNT_WIDTH-1:0] acc_cnt,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);

  localparam logic [CNT_WIDTH-1:0] ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_hit;
  logic [CNT_WIDTH-1:0] r_miss;

  // Count one access per enable, split by hit flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_hit  <= '0;
      r_miss <= '0;
    end else if (en) begin
      r_acc <= r_acc + ONE;
      if (hit) r_hit  <= r_hit + ONE;
      else     r_miss <= r_miss + ONE;
    end
  end

  assign acc_cnt  = r_acc;
  assign hit_cnt  = r_hit;
  assign miss_cnt = r_miss;

endmodule

// File: rtl/dmem_req_ctrl.sv
// MEM-stage data request controller: IDLE/ISSUE/WAIT/RESP.
// Optional statistics counters enabled by macro DMEM_STATS_EN.
module dmem_req_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_read,
  input  logic                 req_write,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 stall,
  output logic [31:0]          rdata,
  output logic                 rdata_valid,
  output logic                 misalign_err,
  input  logic                 cache_is_ready,
  input  logic                 cache_is_output_valid,
  input  logic                 cache_is_hit,
  input  logic [31:0]          cache_dout,
  output logic                 cache_is_input_valid,
  output logic                 cache_mem_read,
  output logic                 cache_mem_write,
  output logic [31:0]          cache_addr,
  output logic [31:0]          cache_din,
  output logic [CNT_WIDTH-1:0] acc_cnt,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);

  state_t      r_state;
  state_t      w_next;
  logic        r_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        w_req;
  logic        w_aligned;
  logic        w_accept;

  assign w_req     = req_valid & (req_read | req_write);
  assign w_aligned = is_aligned(req_addr[WORD_OFS-1:0]);
  assign w_accept  = (r_state == S_IDLE) & w_req
                   & w_aligned & cache_is_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and all state-derived outputs
  always_comb begin
    w_next               = r_state;
    stall                = 1'b0;
    misalign_err         = 1'b0;
    rdata_valid          = 1'b0;
    cache_is_input_valid = 1'b0;
    cache_mem_read       = 1'b0;
    cache_mem_write      = 1'b0;
    cache_addr           = '0;
    cache_din            = '0;
    unique case (r_state)
      S_IDLE: begin
        stall        = reset & w_req & w_aligned;
        misalign_err = reset & w_req & ~w_aligned;
        if (w_accept) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        stall                = 1'b1;
        cache_is_input_valid = 1'b1;
        cache_mem_read       = ~r_wr;
        cache_mem_write      = r_wr;
        cache_addr           = r_addr;
        cache_din            = r_wdata;
        w_next               = S_WAIT;
      end
      S_WAIT: begin
        stall           = 1'b1;
        cache_mem_read  = ~r_wr;
        cache_mem_write = r_wr;
        cache_addr      = r_addr;
        cache_din       = r_wdata;
        if (cache_is_output_valid) w_next = S_RESP;
      end
      S_RESP: begin
        rdata_valid = ~r_wr;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the accepted request; read+write resolves to write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_wr    <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Capture load data on cache response; held until next load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if ((r_state == S_WAIT)
                 && cache_is_output_valid && !r_wr) begin
      r_rdata <= cache_dout;
    end
  end

  assign rdata = r_rdata;

`ifdef DMEM_STATS_EN
  logic r_hit;

  // Capture the hit flag alongside the response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit <= 1'b0;
    end else if ((r_state == S_WAIT) && cache_is_output_valid) begin
      r_hit <= cache_is_hit;
    end
  end

  dmem_stat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stat (
    .clk      (clk),
    .rst_n    (reset),
    .en       (r_state == S_RESP),
    .hit      (r_hit),
    .acc_cnt  (acc_cnt),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );
`else
  logic w_unused_hit;
  assign w_unused_hit = cache_is_hit;
  assign acc_cnt      = '0;
  assign hit_cnt      = '0;
  assign miss_cnt     = '0;
`endif

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed bench for dmem_req_ctrl.
// Counter expectations follow DMEM_STATS_EN.
module tb_dmem_req_ctrl;

  localparam int CW = 4;
`ifdef DMEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_read, req_write;
  logic [31:0]   req_addr, req_wdata;
  logic          stall, rdata_valid, misalign_err;
  logic [31:0]   rdata;
  logic          cache_is_ready, cache_is_output_valid, cache_is_hit;
  logic [31:0]   cache_dout;
  logic          cache_is_input_valid, cache_mem_read, cache_mem_write;
  logic [31:0]   cache_addr, cache_din;
  logic [CW-1:0] acc_cnt, hit_cnt, miss_cnt;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int exp_acc = 0, exp_hit = 0, exp_miss = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  dmem_req_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_valid             (req_valid),
    .req_read              (req_read),
    .req_write             (req_write),
    .req_addr              (req_addr),
    .req_wdata             (req_wdata),
    .stall                 (stall),
    .rdata                 (rdata),
    .rdata_valid           (rdata_valid),
    .misalign_err          (misalign_err),
    .cache_is_ready        (cache_is_ready),
    .cache_is_output_valid (cache_is_output_valid),
    .cache_is_hit          (cache_is_hit),
    .cache_dout            (cache_dout),
    .cache_is_input_valid  (cache_is_input_valid),
    .cache_mem_read        (cache_mem_read),
    .cache_mem_write       (cache_mem_write),
    .cache_addr            (cache_addr),
    .cache_din             (cache_din),
    .acc_cnt               (acc_cnt),
    .hit_cnt               (hit_cnt),
    .miss_cnt              (miss_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    logic [31:0] ea, eh, em;
    ea = STATS ? 32'(exp_acc % (1 << CW)) : 32'd0;
    eh = STATS ? 32'(exp_hit % (1 << CW)) : 32'd0;
    em = STATS ? 32'(exp_miss % (1 << CW)) : 32'd0;
    chk({tag, "_acc"}, 32'(acc_cnt), ea);
    chk({tag, "_hit"}, 32'(hit_cnt), eh);
    chk({tag, "_miss"}, 32'(miss_cnt), em);
  endtask

  // One request; cache answers on the waits-th WAIT cycle,
  // cache_is_ready held low for the first rdy cycles.
  task automatic run_req(input logic rd, input logic wr,
                         input logic [31:0] addr,
                         input logic [31:0] wd,
                         input int rdy, input int waits,
                         input logic hit,
                         input logic [31:0] dout,
                         input string tag);
    int st = 0, iv = 0, rv = 0, stab = 0;
    int iv_c = -1, end_c = -1, phase = 0, wc = 0;
    logic saw_w = 1'b0, saw_r = 1'b0;
    bit done = 1'b0;
    bit ld;
    ld = rd & ~wr;
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_addr = addr; req_wdata = wd;
    cache_is_ready = 1'b0; cache_is_output_valid = 1'b0;
    cache_is_hit = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      st += int'(stall);
      iv += int'(cache_is_input_valid);
      rv += int'(rdata_valid);
      if (cache_addr === addr && cache_din === wd) stab++;
      if (phase != 0 && !stall && end_c < 0) end_c = c;
      if (c == rdy) cache_is_ready = 1'b1;
      case (phase)
        0: if (cache_is_input_valid) begin
          iv_c = c; saw_w = cache_mem_write;
          saw_r = cache_mem_read;
          req_valid = 1'b0; phase = 1;
        end
        1: begin
          wc++;
          if (wc == waits) begin
            cache_is_output_valid = 1'b1;
            cache_is_hit = hit; cache_dout = dout;
            phase = 2;
          end
        end
        2: begin
          cache_is_output_valid = 1'b0; phase = 3;
        end
        default: done = 1'b1;
      endcase
      if (!done) @(posedge clk);
    end
    req_valid = 1'b0;
    cache_is_output_valid = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    if (done) begin
      exp_acc++;
      if (hit) exp_hit++;
      else exp_miss++;
    end
    if (ld) exp_rdata = dout;
    chk({tag, "_stall_cyc"}, st, rdy + 2 + waits);
    chk({tag, "_ivalid_cnt"}, iv, 1);
    chk({tag, "_ivalid_cyc"}, iv_c, rdy + 1);
    chk({tag, "_resp_cyc"}, end_c, rdy + 2 + waits);
    chk({tag, "_addr_stable"}, stab, waits + 1);
    chk({tag, "_rvalid_cnt"}, rv, ld ? 1 : 0);
    chk({tag, "_mem_write"}, 32'(saw_w), 32'(wr));
    chk({tag, "_mem_read"}, 32'(saw_r), 32'(ld));
    chk({tag, "_rdata"}, rdata, exp_rdata);
    chk_cnt(tag);
  endtask

  initial begin
    int n_iv, n_rv, n_st;
    reset = 1'b0;
    req_valid = 0; req_read = 0; req_write = 0;
    req_addr = '0; req_wdata = '0;
    cache_is_ready = 1'b1; cache_is_output_valid = 1'b0;
    cache_is_hit = 1'b0; cache_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_ivalid", 32'(cache_is_input_valid), 0);
    chk("rst_rvalid", 32'(rdata_valid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", cache_addr, 0);
    chk_cnt("rst");
    req_valid = 1'b1; req_read = 1'b1; req_addr = 32'h40;
    #1;
    chk("rst_stall_gated", 32'(stall), 0);
    req_valid = 1'b0; req_read = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    run_req(1, 0, 32'h0000_0040, 32'h0, 0, 1, 1,
            32'hDEAD_BEEF, "load_hit");
    run_req(0, 1, 32'h0000_0100, 32'h1234_5678, 0, 40, 0,
            32'h0, "store_miss");

    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
    req_addr = 32'h0000_0042; cache_is_ready = 1'b1;
    #1;
    chk("mis_err", 32'(misalign_err), 1);
    chk("mis_stall", 32'(stall), 0);
    n_iv = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      n_iv += int'(cache_is_input_valid);
    end
    chk("mis_no_ivalid", n_iv, 0);
    chk("mis_rdata", rdata, exp_rdata);
    chk_cnt("mis");
    req_valid = 1'b0; req_read = 1'b0;
    #1;
    chk("mis_err_clear", 32'(misalign_err), 0);

    run_req(1, 0, 32'h0000_0080, 32'h0, 5, 1, 1,
            32'hCAFE_F00D, "ready_wait");
    run_req(1, 1, 32'h0000_0204, 32'hA5A5_0F0F, 0, 3, 1,
            32'h0, "rw_as_write");

    @(posedge clk); #1;
    req_valid = 1'b1; req_read = 1'b1; req_addr = 32'h0000_0300;
    cache_is_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstw_issue", 32'(cache_is_input_valid), 1);
    @(posedge clk); #1;
    chk("rstw_wait_stall", 32'(stall), 1);
    req_valid = 1'b1;
    reset = 1'b0;
    #1;
    exp_acc = 0; exp_hit = 0; exp_miss = 0; exp_rdata = '0;
    chk("rstw_stall", 32'(stall), 0);
    chk("rstw_ivalid", 32'(cache_is_input_valid), 0);
    chk("rstw_rdata", rdata, 0);
    chk_cnt("rstw");
    req_valid = 1'b0; req_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    n_rv = 0; n_st = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      n_rv += int'(rdata_valid);
      n_st += int'(stall);
    end
    chk("rstw_no_rvalid", n_rv, 0);
    chk("rstw_no_stall", n_st, 0);
    run_req(1, 0, 32'h0000_0300, 32'h0, 0, 2, 0,
            32'h0BAD_CAFE, "after_rst");

    for (int i = 0; i < 16; i++) begin
      run_req(1, 0, 32'h0000_0400 + 32'(i * 4), 32'h0, 0, 1, 1,
              32'hA500_0000 + 32'(i), "wrap");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_req_ctrl.md
DMEM_REQ_CTRL -- requirements
Module: dmem_req_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, width of the statistics counters.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, MEM-stage instruction present.
REQ-005 SHALL have ports req_read / req_write, input, 1 each, load / store request.
REQ-006 SHALL have ports req_addr / req_wdata, input, 32 each, byte address / store data.
REQ-007 SHALL have port stall, output, 1, freeze the pipeline in front of and including the MEM stage.
REQ-008 SHALL have ports rdata / rdata_valid / misalign_err, output, 32/1/1, load result, result strobe, alignment fault.
REQ-009 SHALL have ports cache_is_ready / cache_is_output_valid / cache_is_hit, input, 1 each, from cache.
REQ-010 SHALL have port cache_dout, input, 32, cache read word.
REQ-011 SHALL have ports cache_is_input_valid / cache_mem_read / cache_mem_write, output, 1 each, to cache.
REQ-012 SHALL have ports cache_addr / cache_din, output, 32 each, to cache.
REQ-013 SHALL have ports acc_cnt / hit_cnt / miss_cnt, output, CNT_WIDTH each, statistics.

Function
REQ-014 SHALL implement FSM IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE: accepted request = req_valid & (req_read | req_write) & req_addr[1:0]==0 & cache_is_ready; on acceptance, SHALL latch op/addr/wdata and go to ISSUE.
REQ-016 ISSUE: SHALL drive cache_is_input_valid=1 for exactly this one cycle, then go to WAIT.
REQ-017 cache_addr/cache_din/cache_mem_read/cache_mem_write SHALL come from the latched copy and stay constant from ISSUE through WAIT; they SHALL be 0 in IDLE and RESP.
REQ-018 WAIT: on cache_is_output_valid=1, SHALL capture cache_dout (loads only) and cache_is_hit, then go to RESP; otherwise stay in WAIT, with no timeout.
REQ-019 RESP: SHALL assert rdata_valid=1 for one cycle for loads (0 for stores), ignore req_valid, and return to IDLE.
REQ-020 rdata SHALL hold its last captured value until the next load completes.
REQ-021 stall SHALL be combinational: 1 when (IDLE & req_valid & (req_read|req_write) & aligned), or in ISSUE or WAIT; 0 in RESP.
REQ-022 In IDLE, an aligned request with cache_is_ready=0 SHALL keep stall=1 and remain in IDLE until ready.
REQ-023 A misaligned request in IDLE SHALL produce no cache request, assert misalign_err=1 combinationally, and keep stall=0.
REQ-024 req_read & req_write both 1 SHALL be treated as a write.
REQ-025 Minimum load/store latency from acceptance SHALL be 4 cycles (IDLE, ISSUE, WAIT, RESP) when the cache hits in the first WAIT cycle.

Reset
REQ-026 Asserting reset (low) SHALL immediately force IDLE; stall, rdata_valid, and cache_is_input_valid SHALL be 0, and rdata and all counters SHALL be 0.
REQ-027 Reset asserted mid-transaction SHALL discard the transaction with no completion strobe; deassertion SHALL resume in IDLE.

Configuration
REQ-028 With DMEM_STATS_EN defined, each RESP SHALL increment acc_cnt and exactly one of hit_cnt/miss_cnt (by the captured hit flag), with wrap-around at 2^CNT_WIDTH.
REQ-029 Without DMEM_STATS_EN, acc_cnt/hit_cnt/miss_cnt SHALL be tied to 0 and the counter logic SHALL be absent.

Structure
REQ-030 FSM state encodings SHALL live in shared package dmem_ctrl_pkg, alongside the word-offset constant 2.
REQ-031 Counters SHALL be one sub-module dmem_stat_counter (enable, hit, async active-low clear), instantiated only under DMEM_STATS_EN.

Verification
REQ-032 Load 0x0000_0040 with cache hit after 1 WAIT cycle, dout=0xDEAD_BEEF -> stall high 3 cycles, rdata=0xDEADBEEF, rdata_valid pulses once, hit_cnt=1.
REQ-033 Store 0x0000_0100 data 0x1234_5678 with miss taking 40 WAIT cycles -> cache_is_input_valid single pulse, cache_addr/din stable 41 cycles, rdata_valid=0, miss_cnt=1.
REQ-034 Load 0x0000_0042 -> misalign_err=1, stall=0, no cache_is_input_valid, counters unchanged.
REQ-035 cache_is_ready=0 for 5 cycles with a pending load -> stall high throughout, ISSUE entered only after ready rises.
REQ-036 reset low during WAIT -> stall=0 and counters 0 immediately; no rdata_valid after deassertion; the next request completes normally.
REQ-037 Counters preloaded at 2^CNT_WIDTH-1 with DMEM_STATS_EN, then one hit -> acc_cnt and hit_cnt wrap to 0.
